// File: rtl/pacman_led_pkg.sv
// pacman_led_pkg: shared types and constants for the Pac-Man LED driver.
//   mode_t      : LED display mode (STEADY, BLINK, CHASE, RSVD)
//   ADDR_*      : Avalon-MM register addresses
//   DUTY_RST    : DUTY reset value, all-ones (truncated to PWM_BITS by the user)
//   PERIOD_RST  : PERIOD reset value in ticks per half-period
package pacman_led_pkg;

    typedef enum logic [1:0] {
        STEADY = 2'd0,
        BLINK  = 2'd1,
        CHASE  = 2'd2,
        RSVD   = 2'd3
    } mode_t;

    localparam logic [1:0] ADDR_DUTY   = 2'd0;
    localparam logic [1:0] ADDR_PERIOD = 2'd1;
    localparam logic [1:0] ADDR_MODE   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam logic [31:0] DUTY_RST   = 32'hFFFF_FFFF;
    localparam logic [15:0] PERIOD_RST = 16'd500;

endpackage

// File: rtl/pacman_led_pwm.sv
// pacman_led_pwm: free-running PWM counter and duty comparator.
//   clk     : clock
//   reset_n : asynchronous active-low reset
//   duty    : duty threshold; all-ones means fully on, zero means off
//   pwm_on  : high while the LED enable phase of the PWM period is active
module pacman_led_pwm #(
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [PWM_BITS-1:0] duty,
    output logic                pwm_on
);

    logic [PWM_BITS-1:0] pwm_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pwm_cnt <= '0;
        else          pwm_cnt <= pwm_cnt + 1'b1;
    end

    // A plain compare would leave one dark count per period at full duty.
    always_comb begin
        if (&duty) pwm_on = 1'b1;
        else       pwm_on = (pwm_cnt < duty);
    end

endmodule

// File: rtl/pacman_led_driver.sv
// pacman_led_driver: Avalon-MM controlled LED driver with PWM dimming,
// blink and optional chase modes.
//   clk, reset_n        : clock, asynchronous active-low reset
//   pattern_in          : LED pattern from upstream PIO (same clock domain)
//   address, chipselect,
//   write_n, writedata  : Avalon-MM slave write port
//   readdata            : combinational register read data
//   led_out             : registered LED drive
// Build option: define PACMAN_LED_DRIVER_CHASE_EN to include CHASE mode and
// the chase index; otherwise a MODE write of 2 stores STEADY.
module pacman_led_driver
    import pacman_led_pkg::*;
#(
    parameter int unsigned NUM_LEDS = 14,
    parameter int unsigned PWM_BITS = 8,
    parameter int unsigned TICK_DIV = 50000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_LEDS-1:0] pattern_in,
    input  logic [1:0]          address,
    input  logic                chipselect,
    input  logic                write_n,
    input  logic [31:0]         writedata,
    output logic [31:0]         readdata,
    output logic [NUM_LEDS-1:0] led_out
);

    localparam int unsigned         PRESC_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0]  PRESC_MAX = PRESC_W'(TICK_DIV - 1);

    logic [NUM_LEDS-1:0] pattern_q;
    logic [NUM_LEDS-1:0] led_next;
    logic [PWM_BITS-1:0] duty;
    logic [15:0]         period;
    logic [15:0]         period_m1;
    logic [15:0]         hp_cnt;
    mode_t               mode;
    mode_t               mode_wdata;
    logic [PRESC_W-1:0]  presc;
    logic                tick;
    logic                expire;
    logic                wr_en;
    logic                mode_wr;
    logic                blink_phase;
    logic                pwm_on;
    logic [7:0]          status_idx;
    logic                unused_wdata;

    assign unused_wdata = ^writedata[31:16];

    assign wr_en   = chipselect & ~write_n;
    assign mode_wr = wr_en && (address == ADDR_MODE);

    always_comb begin
`ifdef PACMAN_LED_DRIVER_CHASE_EN
        mode_wdata = mode_t'(writedata[1:0]);
`else
        mode_wdata = (writedata[1:0] == CHASE) ? STEADY : mode_t'(writedata[1:0]);
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            duty   <= DUTY_RST[PWM_BITS-1:0];
            period <= PERIOD_RST;
            mode   <= STEADY;
        end else if (wr_en) begin
            case (address)
                ADDR_DUTY:   duty   <= writedata[PWM_BITS-1:0];
                ADDR_PERIOD: period <= writedata[15:0];
                ADDR_MODE:   mode   <= mode_wdata;
                default:     ;
            endcase
        end
    end

    pacman_led_pwm #(.PWM_BITS(PWM_BITS)) u_pwm (
        .clk     (clk),
        .reset_n (reset_n),
        .duty    (duty),
        .pwm_on  (pwm_on)
    );

    // Blink tick prescaler; deliberately untouched by MODE writes.
    assign tick = (presc == PRESC_MAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  presc <= '0;
        else if (tick) presc <= '0;
        else           presc <= presc + 1'b1;
    end

    // PERIOD = 0 behaves as 1. The >= compare lets a shrunk PERIOD expire
    // on the next tick instead of counting through a wrap.
    assign period_m1 = (period == 16'd0) ? 16'd0 : period - 16'd1;
    assign expire    = tick && (hp_cnt >= period_m1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hp_cnt      <= '0;
            blink_phase <= 1'b1;
        end else if (mode_wr) begin
            hp_cnt      <= '0;
            blink_phase <= 1'b1;
        end else if (expire) begin
            hp_cnt      <= '0;
            blink_phase <= ~blink_phase;
        end else if (tick) begin
            hp_cnt      <= hp_cnt + 16'd1;
        end
    end

`ifdef PACMAN_LED_DRIVER_CHASE_EN
    logic [7:0] chase_idx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     chase_idx <= '0;
        else if (mode_wr) chase_idx <= '0;
        else if (expire)  chase_idx <= (chase_idx == 8'(NUM_LEDS - 1)) ? 8'd0 : chase_idx + 8'd1;
    end

    assign status_idx = chase_idx;
`else
    assign status_idx = '0;
`endif

    always_comb begin
        led_next = '0;
        case (mode)
            BLINK:   led_next = pattern_q & {NUM_LEDS{pwm_on & blink_phase}};
`ifdef PACMAN_LED_DRIVER_CHASE_EN
            CHASE:   led_next = pattern_q & (NUM_LEDS'(1) << chase_idx) & {NUM_LEDS{pwm_on}};
`endif
            default: led_next = pattern_q & {NUM_LEDS{pwm_on}};
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pattern_q <= '0;
            led_out   <= '0;
        end else begin
            pattern_q <= pattern_in;
            led_out   <= led_next;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DUTY:   readdata = 32'(duty);
            ADDR_PERIOD: readdata = {16'h0, period};
            ADDR_MODE:   readdata = {30'h0, mode};
            default:     readdata = {16'h0, status_idx, 7'h0, blink_phase};
        endcase
    end

endmodule

// File: tb/tb_pacman_led_driver.sv
// tb_pacman_led_driver: directed self-checking bench. dut_a runs with
// TICK_DIV = 4, dut_b with TICK_DIV = 2; both share every input.
module tb_pacman_led_driver;
    import pacman_led_pkg::*;

    logic        clk;
    logic        reset_n;
    logic [13:0] pattern_in;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata_a, readdata_b;
    logic [13:0] led_a, led_b;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [31:0] ra, rb;
    logic [13:0] pa, pb, ca, cb;
    int          fa, fb, la, lb, ta, tb, bad, cnt_on, cnt_other, found;
    int          prev_idx, cur_idx, last_chg, wraps;
    logic        prev_ph;

    pacman_led_driver #(.NUM_LEDS(14), .PWM_BITS(8), .TICK_DIV(4)) dut_a (
        .clk(clk), .reset_n(reset_n), .pattern_in(pattern_in), .address(address),
        .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
        .readdata(readdata_a), .led_out(led_a)
    );

    pacman_led_driver #(.NUM_LEDS(14), .PWM_BITS(8), .TICK_DIV(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .pattern_in(pattern_in), .address(address),
        .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
        .readdata(readdata_b), .led_out(led_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Called at (or just after) a falling edge; the write lands on the next rising edge.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] da, output logic [31:0] db);
        address = a;
        #1;
        da = readdata_a;
        db = readdata_b;
    endtask

    task automatic check_reset_regs(input string who);
        rd(ADDR_DUTY, ra, rb);   check_eq({who, "_duty_a"}, ra, 32'hFF);   check_eq({who, "_duty_b"}, rb, 32'hFF);
        rd(ADDR_PERIOD, ra, rb); check_eq({who, "_period_a"}, ra, 32'd500); check_eq({who, "_period_b"}, rb, 32'd500);
        rd(ADDR_MODE, ra, rb);   check_eq({who, "_mode_a"}, ra, 32'd0);    check_eq({who, "_mode_b"}, rb, 32'd0);
        rd(ADDR_STATUS, ra, rb); check_eq({who, "_status_a"}, ra, 32'd1);  check_eq({who, "_status_b"}, rb, 32'd1);
    endtask

    initial begin
        reset_n    = 1'b0;
        pattern_in = '0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_led_a", 32'(led_a), 32'h0);
        check_eq("rst_led_b", 32'(led_b), 32'h0);
        check_reset_regs("rst");

        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // Register access: unused bits dropped, addr 3 and unselected writes ignored
        bus_write(ADDR_DUTY, 32'hABCD_EF12);
        rd(ADDR_DUTY, ra, rb);   check_eq("duty_trunc", ra, 32'h12);
        bus_write(ADDR_PERIOD, 32'h1234_0007);
        rd(ADDR_PERIOD, ra, rb); check_eq("period_trunc", ra, 32'h7);
        bus_write(ADDR_STATUS, 32'hFFFF_FFFF);
        rd(ADDR_DUTY, ra, rb);   check_eq("st_wr_duty", ra, 32'h12);
        rd(ADDR_PERIOD, ra, rb); check_eq("st_wr_period", ra, 32'h7);
        rd(ADDR_MODE, ra, rb);   check_eq("st_wr_mode", ra, 32'h0);
        address = ADDR_DUTY; writedata = 32'h55; chipselect = 1'b0; write_n = 1'b0;
        @(negedge clk);
        write_n = 1'b1;
        rd(ADDR_DUTY, ra, rb);   check_eq("nocs_duty", ra, 32'h12);
        bus_write(ADDR_DUTY, 32'hFF);
        bus_write(ADDR_PERIOD, 32'd500);

        // Two-cycle pattern latency, steady full brightness
        @(negedge clk);
        pattern_in = 14'h3FFF;
        @(negedge clk);
        check_eq("lat_cycle1", 32'(led_a), 32'h0);
        @(negedge clk);
        check_eq("lat_cycle2", 32'(led_a), 32'h3FFF);
        bad = 0;
        repeat (300) begin
            @(negedge clk);
            if (led_a !== 14'h3FFF || led_b !== 14'h3FFF) bad++;
        end
        check_eq("steady_const", 32'(bad), 32'd0);

        // PWM duty 64/256 and 0
        bus_write(ADDR_DUTY, 32'd64);
        repeat (3) @(negedge clk);
        cnt_on = 0; cnt_other = 0;
        repeat (256) begin
            @(negedge clk);
            if (led_a === 14'h3FFF) cnt_on++;
            else if (led_a !== 14'h0) cnt_other++;
        end
        check_eq("pwm64_on", 32'(cnt_on), 32'd64);
        check_eq("pwm64_other", 32'(cnt_other), 32'd0);
        bus_write(ADDR_DUTY, 32'd0);
        repeat (3) @(negedge clk);
        cnt_on = 0;
        repeat (256) begin
            @(negedge clk);
            if (led_a !== 14'h0) cnt_on++;
        end
        check_eq("pwm0_dark", 32'(cnt_on), 32'd0);
        bus_write(ADDR_DUTY, 32'hFF);

        // Reserved mode reads back 3 and is steady
        bus_write(ADDR_MODE, 32'd3);
        rd(ADDR_MODE, ra, rb); check_eq("mode3_read", ra, 32'd3);
        @(negedge clk); @(negedge clk);
        check_eq("mode3_led", 32'(led_a), 32'h3FFF);

        // BLINK: PERIOD 3 -> 12 cycles per half on dut_a, 6 on dut_b
        bus_write(ADDR_PERIOD, 32'd3);
        bus_write(ADDR_MODE, 32'd1);
        @(negedge clk);
        pa = led_a; pb = led_b;
        check_eq("blink_start_a", 32'(pa), 32'h3FFF);
        check_eq("blink_start_b", 32'(pb), 32'h3FFF);
        fa = -1; fb = -1; la = 0; lb = 0; ta = 0; tb = 0; bad = 0;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            ca = led_a; cb = led_b;
            if ((ca !== 14'h0 && ca !== 14'h3FFF) || (cb !== 14'h0 && cb !== 14'h3FFF)) bad++;
            if (ca !== pa) begin
                if (fa < 0) fa = i; else if (i - la != 12) bad++;
                la = i; ta++;
            end
            if (cb !== pb) begin
                if (fb < 0) fb = i; else if (i - lb != 6) bad++;
                lb = i; tb++;
            end
            pa = ca; pb = cb;
        end
        check_eq("blink_gaps", 32'(bad), 32'd0);
        check_eq("blink_first_a", 32'(fa >= 9 && fa <= 12), 32'd1);
        check_eq("blink_first_b", 32'(fb >= 5 && fb <= 6), 32'd1);
        check_eq("blink_count_a", 32'(ta >= 6), 32'd1);
        check_eq("blink_count_b", 32'(tb >= 12), 32'd1);

        // Shrinking PERIOD well below the running count
        bus_write(ADDR_PERIOD, 32'd300);
        bus_write(ADDR_MODE, 32'd1);
        repeat (810) @(negedge clk);
        rd(ADDR_STATUS, ra, rb);
        check_eq("long_period_phase", ra & 32'h1, 32'h1);
        bus_write(ADDR_PERIOD, 32'd1);
        found = -1;
        for (int i = 0; i <= 10; i++) begin
            rd(ADDR_STATUS, ra, rb);
            if (ra[0] == 1'b0) begin found = i; break; end
            @(negedge clk);
        end
        check_eq("shrink_toggle", 32'(found >= 1 && found <= 4), 32'd1);

        // MODE write coinciding with an expiry (PERIOD 2 on dut_a)
        bus_write(ADDR_PERIOD, 32'd2);
        rd(ADDR_STATUS, ra, rb);
        prev_ph = ra[0];
        found = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            rd(ADDR_STATUS, ra, rb);
            if (!prev_ph && ra[0]) begin found = 1; break; end
            prev_ph = ra[0];
        end
        check_eq("expiry_seen", 32'(found), 32'd1);
        repeat (7) @(negedge clk);
        bus_write(ADDR_MODE, 32'd1);
        rd(ADDR_STATUS, ra, rb); check_eq("restart_prio", ra & 32'h1, 32'h1);
        repeat (4) @(negedge clk);
        rd(ADDR_STATUS, ra, rb); check_eq("restart_cnt_hold", ra & 32'h1, 32'h1);
        repeat (4) @(negedge clk);
        rd(ADDR_STATUS, ra, rb); check_eq("restart_cnt_exp", ra & 32'h1, 32'h0);

        // CHASE (dut_b: TICK_DIV 2, PERIOD 1) or its absence
        bus_write(ADDR_PERIOD, 32'd1);
        bus_write(ADDR_MODE, 32'd2);
        rd(ADDR_MODE, ra, rb);
        if (rb == 32'd2) begin
            rd(ADDR_STATUS, ra, rb);
            check_eq("chase_idx0", (rb >> 8) & 32'hFF, 32'd0);
            prev_idx = 0; last_chg = -1; wraps = 0; bad = 0;
            for (int i = 1; i <= 60; i++) begin
                @(negedge clk);
                rd(ADDR_STATUS, ra, rb);
                cur_idx = int'(rb[15:8]);
                if (led_b !== (14'h1 << prev_idx)) bad++;
                if (cur_idx != prev_idx) begin
                    if (cur_idx != (prev_idx + 1) % 14) bad++;
                    if (last_chg >= 0 && i - last_chg != 2) bad++;
                    if (prev_idx == 13 && cur_idx == 0) wraps++;
                    last_chg = i;
                end
                prev_idx = cur_idx;
            end
            check_eq("chase_walk", 32'(bad), 32'd0);
            check_eq("chase_wraps", 32'(wraps >= 2), 32'd1);
        end else begin
            check_eq("nochase_mode", rb, 32'd0);
            rd(ADDR_STATUS, ra, rb);
            check_eq("nochase_idx", (rb >> 8) & 32'hFF, 32'd0);
            @(negedge clk); @(negedge clk);
            check_eq("nochase_led", 32'(led_b), 32'h3FFF);
        end

        // Asynchronous reset mid-sequence
        @(negedge clk);
        check_eq("pre_reset_led", 32'(led_b != 14'h0), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("async_led_a", 32'(led_a), 32'h0);
        check_eq("async_led_b", 32'(led_b), 32'h0);
        check_reset_regs("async");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("resume_cycle1", 32'(led_a), 32'h0);
        @(negedge clk);
        check_eq("resume_cycle2", 32'(led_a), 32'h3FFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
